// File: rtl/pmod_ssd_capture.sv
`default_nettype none
// ============================================================================
// Module   : pmod_ssd_capture
// Brief    : Samples the multiplexed PmodSSD bus, decodes both digits back to
//            hex, and publishes one validated two-digit frame per select cycle.
//            Optional macro SSD_CAPTURE_CONFIRM_EN: publish a frame only when
//            it repeats the preceding completed frame.
// Revision : 1.0 - initial release
// ============================================================================
module pmod_ssd_capture #(
    parameter int PAR_SETTLE_CYCLES  = 1000,
    parameter int PAR_TIMEOUT_CYCLES = 600000
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rst_20mhz,
    input  logic [7:0] i_ssd_pmod,
    output logic [3:0] o_value0,
    output logic [3:0] o_value1,
    output logic [1:0] o_blank,
    output logic [1:0] o_seg_err,
    output logic       o_valid,
    output logic       o_timeout
);

    localparam int c_set_w = $clog2(PAR_SETTLE_CYCLES);
    localparam int c_to_w  = $clog2(PAR_TIMEOUT_CYCLES + 1);

    localparam logic [c_set_w-1:0] c_set_max = c_set_w'(PAR_SETTLE_CYCLES - 1);
    localparam logic [c_set_w-1:0] c_set_one = c_set_w'(1);
    localparam logic [c_to_w-1:0]  c_to_max  = c_to_w'(PAR_TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0]  c_to_hit  = c_to_w'(PAR_TIMEOUT_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_to_one  = c_to_w'(1);

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_SETTLE0 = 3'd1,
        ST_HOLD0   = 3'd2,
        ST_SETTLE1 = 3'd3,
        ST_HOLD1   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0]         r_sync1;
    logic [7:0]         r_sync2;
    logic [7:0]         r_sync_d;
    logic [c_set_w-1:0] r_set_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic               r_timeout;

    logic [3:0] r_hold_val0;
    logic       r_hold_blank0;
    logic       r_hold_err0;

    logic [3:0] r_value0;
    logic [3:0] r_value1;
    logic [1:0] r_blank;
    logic [1:0] r_seg_err;
    logic       r_valid;

    logic        w_sel_edge;
    logic        w_sel_fall;
    logic        w_word_chg;
    logic        w_stable;
    logic        w_to_hit;
    logic        w_latch0;
    logic        w_frame_done;
    logic [5:0]  w_dec_cur;
    logic [11:0] w_frame;

    // Returns {seg_err, blank, value}.
    function automatic logic [5:0] f_decode(input logic [6:0] seg);
        logic [5:0] res;
        res = 6'b10_0000;
        case (seg)
            7'h3F: res = {2'b00, 4'h0};
            7'h06: res = {2'b00, 4'h1};
            7'h5B: res = {2'b00, 4'h2};
            7'h4F: res = {2'b00, 4'h3};
            7'h66: res = {2'b00, 4'h4};
            7'h6D: res = {2'b00, 4'h5};
            7'h7D: res = {2'b00, 4'h6};
            7'h07: res = {2'b00, 4'h7};
            7'h7F: res = {2'b00, 4'h8};
            7'h67: res = {2'b00, 4'h9};
            7'h77: res = {2'b00, 4'hA};
            7'h7C: res = {2'b00, 4'hB};
            7'h39: res = {2'b00, 4'hC};
            7'h5E: res = {2'b00, 4'hD};
            7'h79: res = {2'b00, 4'hE};
            7'h71: res = {2'b00, 4'hF};
            7'h00: res = 6'b01_0000;
            default: res = 6'b10_0000;
        endcase
        return res;
    endfunction

    assign w_sel_edge = r_sync2[7] ^ r_sync_d[7];
    assign w_sel_fall = w_sel_edge && !r_sync2[7];
    assign w_word_chg = (r_sync2 != r_sync_d);
    assign w_stable   = (r_set_cnt == c_set_max) && !w_word_chg;
    // A select edge in the same cycle always beats an expiring timeout.
    assign w_to_hit   = (r_to_cnt == c_to_hit) && !w_sel_edge;
    assign w_dec_cur  = f_decode(r_sync2[6:0]);

    // {value1, value0, blank[1:0], seg_err[1:0]}
    assign w_frame = {w_dec_cur[3:0], r_hold_val0,
                      w_dec_cur[4], r_hold_blank0,
                      w_dec_cur[5], r_hold_err0};

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_sync1  <= 8'h00;
            r_sync2  <= 8'h00;
            r_sync_d <= 8'h00;
        end else begin
            r_sync1  <= i_ssd_pmod;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_set_cnt <= '0;
        end else if (w_word_chg) begin
            r_set_cnt <= '0;
        end else if (r_set_cnt != c_set_max) begin
            r_set_cnt <= r_set_cnt + c_set_one;
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_sel_edge) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_to_cnt != c_to_max) begin
                r_to_cnt <= r_to_cnt + c_to_one;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch0     = 1'b0;
        w_frame_done = 1'b0;
        if (w_to_hit) begin
            w_state_next = ST_SYNC;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (w_sel_fall) begin
                        w_state_next = ST_SETTLE0;
                    end
                end
                ST_SETTLE0: begin
                    if (w_sel_edge) begin
                        w_state_next = ST_SYNC;
                    end else if (w_stable) begin
                        w_latch0     = 1'b1;
                        w_state_next = ST_HOLD0;
                    end
                end
                ST_HOLD0: begin
                    if (w_sel_edge) begin
                        w_state_next = ST_SETTLE1;
                    end
                end
                ST_SETTLE1: begin
                    if (w_sel_edge) begin
                        w_state_next = ST_SETTLE0;
                    end else if (w_stable) begin
                        w_frame_done = 1'b1;
                        w_state_next = ST_HOLD1;
                    end
                end
                ST_HOLD1: begin
                    if (w_sel_edge) begin
                        w_state_next = ST_SETTLE0;
                    end
                end
                default: w_state_next = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_hold_val0   <= 4'h0;
            r_hold_blank0 <= 1'b0;
            r_hold_err0   <= 1'b0;
        end else if (w_latch0) begin
            r_hold_val0   <= w_dec_cur[3:0];
            r_hold_blank0 <= w_dec_cur[4];
            r_hold_err0   <= w_dec_cur[5];
        end
    end

`ifdef SSD_CAPTURE_CONFIRM_EN
    logic [11:0] r_prev_frame;
    logic        r_prev_ok;
    logic        w_drop;

    assign w_drop = w_sel_edge && ((r_state == ST_SETTLE0) || (r_state == ST_SETTLE1));

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_prev_frame <= 12'h000;
            r_prev_ok    <= 1'b0;
            r_value0     <= 4'h0;
            r_value1     <= 4'h0;
            r_blank      <= 2'b00;
            r_seg_err    <= 2'b00;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_drop || w_to_hit) begin
                r_prev_ok <= 1'b0;
            end else if (w_frame_done) begin
                r_prev_frame <= w_frame;
                r_prev_ok    <= 1'b1;
                // Only a frame that repeats its predecessor is trusted.
                if (r_prev_ok && (r_prev_frame == w_frame)) begin
                    {r_value1, r_value0, r_blank, r_seg_err} <= w_frame;
                    r_valid <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_value0  <= 4'h0;
            r_value1  <= 4'h0;
            r_blank   <= 2'b00;
            r_seg_err <= 2'b00;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_frame_done) begin
                {r_value1, r_value0, r_blank, r_seg_err} <= w_frame;
                r_valid <= 1'b1;
            end
        end
    end
`endif

    assign o_value0  = r_value0;
    assign o_value1  = r_value1;
    assign o_blank   = r_blank;
    assign o_seg_err = r_seg_err;
    assign o_valid   = r_valid;
    assign o_timeout = r_timeout;

endmodule
`default_nettype wire
